// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//   Multi-channel switch/button debouncer. Each channel brings its raw input
//   into the i_Clk domain through a two-flop synchroniser. It then accepts a new
//   level only after the synchronised value has disagreed with the current
//   debounced level for THRESHOLD uninterrupted clock edges. If the two agree
//   on any edge, the count accumulated so far is discarded.
//
// Parameters
//   NUM_CH      number of independent channels (>= 1)
//   THRESHOLD   consecutive mismatching edges needed to accept a level (>= 1)
//   CNT_W       per-channel counter width, 2**CNT_W > THRESHOLD
//   INIT_LEVEL  level loaded into synchronisers and debounced state at reset
//
// Ports
//   i_Clk         sole clock, rising edge
//   i_Rst_L       asynchronous active-low reset (deassert synchronously)
//   i_Signal      raw asynchronous inputs, one bit per channel
//   o_Debounced   accepted stable level per channel
//   o_Rise        one-cycle pulse when o_Debounced goes 0->1
//   o_Fall        one-cycle pulse when o_Debounced goes 1->0
//   o_Any_Change  high in any cycle where some o_Rise/o_Fall bit is high
//   o_Busy        high while the channel's counter is non-zero
// -----------------------------------------------------------------------------
module debounce_multi #(
   parameter int NUM_CH     = 4,
   parameter int THRESHOLD  = 100000,
   parameter int CNT_W      = 17,
   parameter bit INIT_LEVEL = 1'b0
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic [NUM_CH-1:0] i_Signal,
   output logic [NUM_CH-1:0] o_Debounced,
   output logic [NUM_CH-1:0] o_Rise,
   output logic [NUM_CH-1:0] o_Fall,
   output logic              o_Any_Change,
   output logic [NUM_CH-1:0] o_Busy
);

   // Reject parameter combinations that cannot work, at elaboration time.
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("debounce_multi: NUM_CH must be >= 1");
   end
   if (THRESHOLD < 1) begin : g_bad_threshold
      $error("debounce_multi: THRESHOLD must be >= 1");
   end
   if (CNT_W < 1 || (CNT_W < 63 && (64'd1 << CNT_W) <= 64'(THRESHOLD))) begin : g_bad_cnt_w
      $error("debounce_multi: 2**CNT_W must exceed THRESHOLD");
   end

   // Count value at which the next mismatching edge completes acceptance.
   // The counter never goes past it, so it cannot wrap.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESHOLD - 1);

   // One bit per channel: this edge loads a new debounced level.
   logic [NUM_CH-1:0] accept;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             sync_a;
      logic             sync_b;
      logic             deb;
      logic             rise;
      logic             fall;
      logic             busy;
      logic [CNT_W-1:0] cnt;
      logic             mismatch;

      assign mismatch  = (sync_b != deb);
      assign accept[c] = mismatch && (cnt == LAST_CNT);

      // NOTE: every register in this block, counter included, takes a defined
      // reset value, so a reset in the middle of a count discards that count.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
         if (!i_Rst_L) begin
            sync_a <= INIT_LEVEL;
            sync_b <= INIT_LEVEL;
            deb    <= INIT_LEVEL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            busy   <= 1'b0;
         end else begin
            // NOTE: non-blocking assignments make sync_b take the old sync_a,
            // which keeps the two synchroniser stages distinct.
            sync_a <= i_Signal[c];
            sync_b <= sync_a;

            // The pulses register on the same edge as the level change, so
            // they are high exactly in the cycle the new level first shows.
            rise <= accept[c] & sync_b;
            fall <= accept[c] & ~sync_b;

            if (accept[c]) begin
               deb <= sync_b;
            end

            // Agreement or acceptance both restart the count. busy tracks the
            // counter's new value, so it is 0 whenever the counter is 0.
            if (!mismatch || accept[c]) begin
               cnt  <= '0;
               busy <= 1'b0;
            end else begin
               cnt  <= cnt + CNT_W'(1);
               busy <= 1'b1;
            end
         end
      end

      assign o_Debounced[c] = deb;
      assign o_Rise[c]      = rise;
      assign o_Fall[c]      = fall;
      assign o_Busy[c]      = busy;
   end

   // accept is exactly the next-cycle value of (o_Rise | o_Fall). Its OR
   // therefore registers in step with the pulses.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_Any_Change <= 1'b0;
      end else begin
         o_Any_Change <= |accept;
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//   Drives two debounce_multi builds from the same inputs: THRESHOLD=4 (dut_a)
//   and THRESHOLD=1 (dut_b). Both use NUM_CH=4 and INIT_LEVEL=0. A reference
//   model follows the acceptance rule directly. A channel accepts its
//   synchronised value once that value has disagreed with the debounced level
//   for THRESHOLD edges since the last agreement or acceptance. The synchronised
//   value is the raw input sampled two edges earlier.
// -----------------------------------------------------------------------------
module tb_debounce_multi;
   localparam int NUM_CH = 4;
   localparam int THR_A  = 4;
   localparam int THR_B  = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] sig = '0;

   logic [NUM_CH-1:0] a_deb, a_rise, a_fall, a_busy;
   logic              a_any;
   logic [NUM_CH-1:0] b_deb, b_rise, b_fall, b_busy;
   logic              b_any;

   always #5 clk = ~clk;

   debounce_multi #(
      .NUM_CH(NUM_CH), .THRESHOLD(THR_A), .CNT_W(3), .INIT_LEVEL(1'b0)
   ) dut_a (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Signal(sig),
      .o_Debounced(a_deb), .o_Rise(a_rise), .o_Fall(a_fall),
      .o_Any_Change(a_any), .o_Busy(a_busy)
   );

   debounce_multi #(
      .NUM_CH(NUM_CH), .THRESHOLD(THR_B), .CNT_W(2), .INIT_LEVEL(1'b0)
   ) dut_b (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Signal(sig),
      .o_Debounced(b_deb), .o_Rise(b_rise), .o_Fall(b_fall),
      .o_Any_Change(b_any), .o_Busy(b_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int                edge_n = 0;
   int                thr [2] = '{THR_A, THR_B};
   logic [NUM_CH-1:0] pipe [$];               // raw samples not yet synchronised
   int                last_evt [2][NUM_CH];   // edge of last agreement/acceptance
   logic [NUM_CH-1:0] m_deb [2];
   logic [NUM_CH-1:0] m_rise [2];
   logic [NUM_CH-1:0] m_fall [2];
   logic [NUM_CH-1:0] m_busy [2];
   logic              m_any [2];

   function automatic void model_reset();
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      for (int d = 0; d < 2; d++) begin
         m_deb[d]  = '0;
         m_rise[d] = '0;
         m_fall[d] = '0;
         m_busy[d] = '0;
         m_any[d]  = 1'b0;
         for (int c = 0; c < NUM_CH; c++) last_evt[d][c] = edge_n;
      end
   endfunction

   function automatic void model_edge(input logic [NUM_CH-1:0] raw);
      logic [NUM_CH-1:0] s;
      edge_n++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      s = pipe.pop_front();
      pipe.push_back(raw);
      for (int d = 0; d < 2; d++) begin
         m_rise[d] = '0;
         m_fall[d] = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (s[c] == m_deb[d][c]) begin
               last_evt[d][c] = edge_n;
            end else if (edge_n - last_evt[d][c] >= thr[d]) begin
               m_deb[d][c]    = s[c];
               m_rise[d][c]   = s[c];
               m_fall[d][c]   = ~s[c];
               last_evt[d][c] = edge_n;
            end
            m_busy[d][c] = (edge_n - last_evt[d][c]) != 0;
         end
         m_any[d] = |(m_rise[d] | m_fall[d]);
      end
   endfunction

   task automatic check_all();
      check("a_deb",  a_deb,  m_deb[0]);
      check("a_rise", a_rise, m_rise[0]);
      check("a_fall", a_fall, m_fall[0]);
      check("a_busy", a_busy, m_busy[0]);
      check("a_any",  a_any,  m_any[0]);
      check("a_excl", a_rise & a_fall, '0);
      check("b_deb",  b_deb,  m_deb[1]);
      check("b_rise", b_rise, m_rise[1]);
      check("b_fall", b_fall, m_fall[1]);
      check("b_busy", b_busy, m_busy[1]);
      check("b_any",  b_any,  m_any[1]);
   endtask

   // Advance one edge: update the model with the inputs sampled on that edge,
   // then check outputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge(sig);
      #1;
      check_all();
   endtask

   task automatic reset_now();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [4:0] bounce;
      bounce = 5'b10110;   // ch1 sequence 1,0,1,1,0, oldest in bit 4

      model_reset();
      #1;
      check_all();
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();

      // Ch0 0->1 held: accepted after edge 6, busy on edges 3-5.
      sig[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 5) check("r028_busy5", a_busy[0], 1'b1);
         if (i == 6) begin
            check("r028_rise6", a_rise, 4'b0001);
            check("r028_any6",  a_any,  1'b1);
            check("r028_deb6",  a_deb[0], 1'b1);
         end
      end

      // Ch1 bounce then held high.
      for (int i = 4; i >= 0; i--) begin
         sig[1] = bounce[i];
         step();
      end
      sig[1] = 1'b1;
      repeat (9) step();
      check("r029_deb1", a_deb[1], 1'b1);

      // Ch2 high for 3 cycles only: never accepted by the THRESHOLD=4 build.
      sig[2] = 1'b1;
      repeat (3) step();
      sig[2] = 1'b0;
      repeat (6) step();
      check("r030_deb2",  a_deb[2],  1'b0);
      check("r030_busy2", a_busy[2], 1'b0);

      // Ch0 falls and ch3 rises together.
      sig[0] = 1'b0;
      sig[3] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 6) begin
            check("r031_fall", a_fall, 4'b0001);
            check("r031_rise", a_rise, 4'b1000);
            check("r031_any",  a_any,  1'b1);
         end
      end

      // Reset mid-count on ch1, then ch3 (still high) is re-accepted.
      sig[1] = 1'b0;
      repeat (4) step();
      check("r032_busy_pre", a_busy[1], 1'b1);
      reset_now();
      check("r032_deb_rst", a_deb, '0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 3) check("r032_b_rise3", b_rise, 4'b1000);
         if (i == 6) check("r027_a_rise6", a_rise, 4'b1000);
      end

      // Random toggling with occasional reset pulses.
      for (int n = 0; n < 800; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(3) == 0) sig[c] = ~sig[c];
         end
         if ($urandom_range(199) == 0) begin
            reset_now();
            step();
            rst_n = 1'b1;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, >= 1.
REQ-002 Parameter THRESHOLD, default 100000: consecutive mismatching clock edges required to accept a new level; shall be >= 1 (elaboration error otherwise).
REQ-003 Parameter CNT_W, default 17: counter width; 2^CNT_W > THRESHOLD (elaboration error otherwise).
REQ-004 Parameter INIT_LEVEL, default 0: 1-bit level loaded into all synchroniser and debounced state at reset.
REQ-005 i_Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_Rst_L  in  1  asynchronous, active-low reset; assertion acts immediately, deassertion is synchronous to i_Clk by the integrator.
REQ-007 i_Signal  in  NUM_CH  raw asynchronous inputs (buttons/switches), one bit per channel.
REQ-008 o_Debounced  out  NUM_CH  accepted stable level per channel, registered.
REQ-009 o_Rise  out  NUM_CH  one-cycle pulse when the channel's o_Debounced goes 0->1.
REQ-010 o_Fall  out  NUM_CH  one-cycle pulse when the channel's o_Debounced goes 1->0.
REQ-011 o_Any_Change  out  1  registered OR of all o_Rise|o_Fall bits of the same cycle.
REQ-012 o_Busy  out  NUM_CH  high while the channel's counter is non-zero (candidate level pending).

Function
REQ-013 Each channel shall pass i_Signal through a 2-flop synchroniser; only the second flop output (sync) feeds the debounce logic.
REQ-014 Each channel shall own a CNT_W-bit counter and a debounced-level register; channels shall share no state except o_Any_Change.
REQ-015 On each edge where sync == o_Debounced, the counter shall load 0.
REQ-016 On each edge where sync != o_Debounced and counter < THRESHOLD-1, the counter shall increment by 1.
REQ-017 On each edge where sync != o_Debounced and counter == THRESHOLD-1, o_Debounced shall load sync and the counter shall load 0 on that same edge.
REQ-018 Counter shall never exceed THRESHOLD-1; no wrap-around shall be reachable.
REQ-019 Latency: a raw change held stable, first sampled at edge 1, shall appear on o_Debounced after edge THRESHOLD+2.
REQ-020 Any single edge with sync == o_Debounced (glitch/bounce) shall discard accumulated count; acceptance requires THRESHOLD uninterrupted mismatching edges.
REQ-021 o_Rise/o_Fall shall be asserted for exactly the cycle following the edge on which o_Debounced changed, registered alongside it; never both high for one channel.
REQ-022 o_Any_Change shall be high in the same cycle as any o_Rise or o_Fall bit, low otherwise.
REQ-023 o_Busy shall equal (counter != 0), registered; with THRESHOLD == 1, o_Busy shall remain 0.
REQ-024 Simultaneous changes on several channels shall be debounced independently and may produce multiple pulse bits in one cycle.

Reset
REQ-025 While i_Rst_L == 0: both synchroniser flops and o_Debounced = INIT_LEVEL on every channel; counters = 0; o_Rise, o_Fall, o_Busy, o_Any_Change = 0.
REQ-026 Reset asserted mid-count shall discard the count; no pulse shall be emitted for reset-induced level changes.
REQ-027 After deassertion, an input differing from INIT_LEVEL shall be accepted via the normal path (REQ-019 latency) and shall produce the corresponding edge pulse.

Verification (THRESHOLD=4, NUM_CH=4, INIT_LEVEL=0 unless stated)
REQ-028 Ch0 0->1 held -> o_Debounced[0]=1 after edge 6, o_Rise=4'b0001 and o_Any_Change=1 for exactly one cycle, o_Busy[0] high edges 3-5.
REQ-029 Ch1 bounce 1,0,1,1,0 then held 1 -> no change until 4 consecutive mismatching edges after last 0; single o_Rise[1] pulse.
REQ-030 Ch2 high for 3 synced cycles then low -> o_Debounced[2] stays 0, no pulse, o_Busy[2] returns to 0.
REQ-031 Ch0 and ch3 change same cycle (1->0 on ch0 after prior acceptance, 0->1 on ch3) -> o_Fall=4'b0001 and o_Rise=4'b1000 in same cycle, o_Any_Change=1.
REQ-032 i_Rst_L pulsed low at counter=2 -> all outputs 0 immediately, counter restarts from 0 after release; THRESHOLD=1 build: acceptance after edge 3, o_Busy always 0.
